// File: rtl/l1d_req_issue_pkg.sv
// Shared L1D request layout and field widths for the requester front end.
package l1d_req_issue_pkg;
    localparam int L1D_TAG_WIDTH     = 4;
    localparam int L1D_INDEX_WIDTH   = 4;
    localparam int L1D_OFFSET_WIDTH  = 4;
    localparam int REQ_DATA_WIDTH    = 64;
    localparam int L1D_MSHR_ID_WIDTH = 5;

    typedef struct packed {
        logic                          op_is_read;
        logic [L1D_TAG_WIDTH-1:0]      tag;
        logic [L1D_INDEX_WIDTH-1:0]    index;
        logic [L1D_OFFSET_WIDTH-1:0]   offset;
        logic [REQ_DATA_WIDTH-1:0]     wr_data;
        logic [REQ_DATA_WIDTH/8-1:0]   wr_data_byte_en;
    } pack_l1d_req;
endpackage

// File: rtl/l1d_req_issue.sv
// CPU load/store -> tagged L1D request; out-of-order L1D responses retire in issue order via a ROB.
// Request 1 cycle after accept, completion 1 cycle after head response; stalls when ROB full or issue reg held.
module l1d_req_issue
    import l1d_req_issue_pkg::*;
#(
    parameter int ROB_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req_vld,
    output logic                          cpu_req_rdy,
    input  logic [11:0]                   cpu_addr,
    input  logic                          cpu_op_is_read,
    input  logic [REQ_DATA_WIDTH-1:0]     cpu_wr_data,
    input  logic [REQ_DATA_WIDTH/8-1:0]   cpu_wr_byte_en,
    output logic                          l1d_req_vld,
    input  logic                          l1d_req_rdy,
    output pack_l1d_req                   l1d_req,
    output logic [L1D_MSHR_ID_WIDTH-1:0]  l1d_req_id,
    input  logic                          l1d_resp_vld,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]  l1d_resp_id,
    input  logic [REQ_DATA_WIDTH-1:0]     l1d_resp_rd_data,
    output logic                          cpu_resp_vld,
    input  logic                          cpu_resp_rdy,
    output logic                          cpu_resp_op_is_read,
    output logic [REQ_DATA_WIDTH-1:0]     cpu_resp_rd_data,
    output logic                          err_unexpected_resp
);
    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDC_W = L1D_MSHR_ID_WIDTH + 1;

    logic [PTR_W-1:0]          alloc_ptr, retire_ptr, resp_idx;
    logic [CNT_W-1:0]          rob_cnt;
    logic [ROB_DEPTH-1:0]      busy, done, slot_is_read;
    logic [REQ_DATA_WIDTH-1:0] slot_data [ROB_DEPTH];
    logic                      live, cpu_acc, retire, resp_ok;
    pack_l1d_req               nxt_req;

    // live keeps cpu_req_rdy low while reset is asserted and for its release cycle
    assign cpu_req_rdy = live && (rob_cnt < CNT_W'(ROB_DEPTH)) && (!l1d_req_vld || l1d_req_rdy);
    assign cpu_acc     = cpu_req_vld && cpu_req_rdy;
    assign resp_idx    = l1d_resp_id[PTR_W-1:0];
    assign resp_ok     = l1d_resp_vld && ({1'b0, l1d_resp_id} < IDC_W'(ROB_DEPTH))
                         && busy[resp_idx] && !done[resp_idx];

    assign cpu_resp_vld        = done[retire_ptr];
    assign cpu_resp_op_is_read = done[retire_ptr] && slot_is_read[retire_ptr];
    assign cpu_resp_rd_data    = done[retire_ptr] ? slot_data[retire_ptr] : '0;
    assign retire              = cpu_resp_vld && cpu_resp_rdy;

    always_comb begin
        nxt_req                 = '0;
        nxt_req.op_is_read      = cpu_op_is_read;
        nxt_req.tag             = cpu_addr[11:8];
        nxt_req.index           = cpu_addr[7:4];
        nxt_req.offset          = cpu_addr[3:0];
        nxt_req.wr_data         = cpu_op_is_read ? '0 : cpu_wr_data;
        nxt_req.wr_data_byte_en = cpu_op_is_read ? '0 : cpu_wr_byte_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live                <= 1'b0;
            l1d_req_vld         <= 1'b0;
            l1d_req             <= '0;
            l1d_req_id          <= '0;
            alloc_ptr           <= '0;
            retire_ptr          <= '0;
            rob_cnt             <= '0;
            busy                <= '0;
            done                <= '0;
            slot_is_read        <= '0;
            err_unexpected_resp <= 1'b0;
            for (int i = 0; i < ROB_DEPTH; i++) slot_data[i] <= '0;
        end else begin
            live <= 1'b1;
            if (cpu_acc) begin
                l1d_req     <= nxt_req;
                l1d_req_id  <= L1D_MSHR_ID_WIDTH'(alloc_ptr);
                l1d_req_vld <= 1'b1;
                alloc_ptr   <= alloc_ptr + PTR_W'(1);
            end else if (l1d_req_rdy) begin
                l1d_req_vld <= 1'b0;
            end

            if (retire) retire_ptr <= retire_ptr + PTR_W'(1);

            case ({cpu_acc, retire})
                2'b10:   rob_cnt <= rob_cnt + CNT_W'(1);
                2'b01:   rob_cnt <= rob_cnt - CNT_W'(1);
                default: ;
            endcase

            if (l1d_resp_vld && !resp_ok) err_unexpected_resp <= 1'b1;

            // retire, alloc and response never target the same slot in one cycle
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (retire && retire_ptr == PTR_W'(i)) begin
                    busy[i] <= 1'b0;
                    done[i] <= 1'b0;
                end
                if (cpu_acc && alloc_ptr == PTR_W'(i)) begin
                    busy[i]         <= 1'b1;
                    slot_is_read[i] <= cpu_op_is_read;
                end
                if (resp_ok && resp_idx == PTR_W'(i)) begin
                    done[i]      <= 1'b1;
                    slot_data[i] <= slot_is_read[i] ? l1d_resp_rd_data : '0;
                end
            end
        end
    end
endmodule
